// File: rtl/subsistema_conversion_inversa_if.sv
// Handshake bundle for the BCD-to-binary converter: packed BCD in with a start flag,
// registered binary result out with done/error pulses and a busy indicator.
interface subsistema_conversion_inversa_if #(
  parameter int DIGITOS       = 3,
  parameter int ANCHO_BINARIO = 10
);
  logic [4*DIGITOS-1:0]     bcdEntrada;
  logic                     banderaLista;
  logic [ANCHO_BINARIO-1:0] resultado;
  logic                     banderaConvertida;
  logic                     banderaError;
  logic                     ocupado;

  modport master (
    output bcdEntrada, banderaLista,
    input  resultado, banderaConvertida, banderaError, ocupado
  );

  modport slave (
    input  bcdEntrada, banderaLista,
    output resultado, banderaConvertida, banderaError, ocupado
  );
endinterface

// File: rtl/subsistema_conversion_inversa.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one right shift of
// {bcd, bin} per clock, then every BCD digit >= 8 is reduced by 3.
module subsistema_conversion_inversa #(
  parameter int DIGITOS       = 3,
  parameter int ANCHO_BINARIO = 10
) (
  input logic                       reloj,
  input logic                       reinicio,
  subsistema_conversion_inversa_if.slave bus
);
  localparam int ANCHO_BCD = 4 * DIGITOS;
  localparam int ANCHO_CNT = (ANCHO_BINARIO > 1) ? $clog2(ANCHO_BINARIO) : 1;
  localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(ANCHO_BINARIO - 1);

  typedef enum logic [1:0] {INACTIVO, CONVIRTIENDO, FINAL, ERROR} estado_t;

  estado_t                  estado_q;
  logic [ANCHO_BCD-1:0]     bcd_q;
  logic [ANCHO_BINARIO-1:0] bin_q;
  logic [ANCHO_CNT-1:0]     cnt_q;
  logic [ANCHO_BINARIO-1:0] resultado_q;
  logic                     convertida_q;
  logic                     error_q;
  logic                     ocupado_q;

  logic [ANCHO_BCD-1:0]     bcd_d;
  logic [ANCHO_BINARIO-1:0] bin_d;

  function automatic logic digitos_validos(input logic [ANCHO_BCD-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITOS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [ANCHO_BCD-1:0] corregir(input logic [ANCHO_BCD-1:0] v);
    logic [ANCHO_BCD-1:0] r;
    r = v;
    for (int i = 0; i < DIGITOS; i++) begin
      if (r[4*i +: 4] >= 4'd8) r[4*i +: 4] = r[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  assign {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;

  // Outputs are registered; ocupado stays high through the done pulse so both fall together.
  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      estado_q     <= INACTIVO;
      bcd_q        <= '0;
      bin_q        <= '0;
      cnt_q        <= '0;
      resultado_q  <= '0;
      convertida_q <= 1'b0;
      error_q      <= 1'b0;
      ocupado_q    <= 1'b0;
    end else begin
      convertida_q <= 1'b0;
      error_q      <= 1'b0;
      case (estado_q)
        INACTIVO: begin
          if (bus.banderaLista) begin
            ocupado_q <= 1'b1;
            if (digitos_validos(bus.bcdEntrada)) begin
              bcd_q    <= bus.bcdEntrada;
              bin_q    <= '0;
              cnt_q    <= '0;
              estado_q <= CONVIRTIENDO;
            end else begin
              estado_q <= ERROR;
            end
          end else begin
            ocupado_q <= 1'b0;
          end
        end
        CONVIRTIENDO: begin
          bcd_q <= corregir(bcd_d);
          bin_q <= bin_d;
          cnt_q <= cnt_q + ANCHO_CNT'(1);
          if (cnt_q == CNT_ULTIMO) estado_q <= FINAL;
        end
        FINAL: begin
          resultado_q  <= bin_q;
          convertida_q <= 1'b1;
          estado_q     <= INACTIVO;
        end
        ERROR: begin
          error_q   <= 1'b1;
          ocupado_q <= 1'b0;
          estado_q  <= INACTIVO;
        end
        default: estado_q <= INACTIVO;
      endcase
    end
  end

  assign bus.resultado         = resultado_q;
  assign bus.banderaConvertida = convertida_q;
  assign bus.banderaError      = error_q;
  assign bus.ocupado           = ocupado_q;
endmodule

// File: tb/tb_subsistema_conversion_inversa.sv
// Scoreboard bench for the BCD-to-binary converter: directed corner cases plus random
// BCD words, with a decimal reference model and a monitor checking every flag pulse.
module tb_subsistema_conversion_inversa;
  logic reloj = 1'b0;
  logic reinicio = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   model_res = 0;

  typedef struct {
    bit es_error;
    int valor;
    int ciclo;
  } esperado_t;

  esperado_t sb[$];

  subsistema_conversion_inversa_if #(.DIGITOS(3), .ANCHO_BINARIO(10)) bus ();

  subsistema_conversion_inversa #(.DIGITOS(3), .ANCHO_BINARIO(10)) dut (
    .reloj    (reloj),
    .reinicio (reinicio),
    .bus      (bus)
  );

  always #5 reloj = ~reloj;
  always @(posedge reloj) cyc++;

  task automatic chk(input string nombre, input int actual, input int requerido);
    checks++;
    if (actual !== requerido) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nombre, actual, actual, requerido, requerido, cyc);
    end
  endtask

  // Decimal interpretation of the BCD word; invalid if any nibble exceeds 9.
  task automatic modelo(input logic [11:0] v, output bit valido, output int valor);
    logic [11:0] t;
    t = v;
    valido = 1'b1;
    valor = 0;
    for (int i = 2; i >= 0; i--) begin
      int d;
      d = int'(t[4*i +: 4]);
      if (d > 9) valido = 1'b0;
      valor = valor * 10 + d;
    end
  endtask

  // Monitor: every done/error pulse must match the head of the scoreboard.
  always @(negedge reloj) begin
    if (!reinicio && (bus.banderaConvertida || bus.banderaError)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL flag_inesperado: conv=%0b err=%0b at cycle %0d, expected no flag",
                 bus.banderaConvertida, bus.banderaError, cyc);
      end else begin
        esperado_t e;
        e = sb.pop_front();
        chk("tipo_flag", int'({bus.banderaError, bus.banderaConvertida}), e.es_error ? 2 : 1);
        chk("ciclo_flag", cyc, e.ciclo);
        chk("resultado", int'(bus.resultado), e.valor);
      end
    end
  end

  task automatic esperar_vacio();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge reloj);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_scoreboard", sb.size(), 0);
      sb.delete();
    end
    @(posedge reloj);
    #1;
  endtask

  // Issue one start pulse at posedge+1; the following edge is the accepting edge.
  task automatic arrancar(input logic [11:0] v);
    bit valido;
    int valor;
    int k;
    esperado_t e;
    modelo(v, valido, valor);
    chk("ocupado_antes", int'(bus.ocupado), 0);
    k = cyc;
    bus.bcdEntrada = v;
    bus.banderaLista = 1'b1;
    if (valido) begin
      e = '{es_error: 1'b0, valor: valor, ciclo: k + 12};
      model_res = valor;
    end else begin
      e = '{es_error: 1'b1, valor: model_res, ciclo: k + 2};
    end
    sb.push_back(e);
    @(posedge reloj);
    #1;
    bus.banderaLista = 1'b0;
    bus.bcdEntrada = 12'($urandom);
    @(negedge reloj);
    chk("ocupado_tras_E0", int'(bus.ocupado), 1);
    esperar_vacio();
  endtask

  task automatic chk_reposo(input string etiqueta);
    chk({etiqueta, "_resultado"}, int'(bus.resultado), 0);
    chk({etiqueta, "_convertida"}, int'(bus.banderaConvertida), 0);
    chk({etiqueta, "_error"}, int'(bus.banderaError), 0);
    chk({etiqueta, "_ocupado"}, int'(bus.ocupado), 0);
  endtask

  initial begin
    logic [11:0] v;
    int k;
    bus.bcdEntrada = '0;
    bus.banderaLista = 1'b0;
    #1 reinicio = 1'b1;
    #2;
    chk_reposo("reset_activo");
    repeat (3) @(posedge reloj);
    #1 reinicio = 1'b0;
    chk_reposo("reset_liberado");
    repeat (20) @(posedge reloj);
    #1;
    chk_reposo("reposo_20");

    arrancar(12'h999);
    arrancar(12'h000);
    arrancar(12'h001);
    arrancar(12'h225);
    arrancar(12'h1A3);
    chk("resultado_tras_error", int'(bus.resultado), 225);

    // Back-to-back: second request held high through FINAL and the done pulse.
    k = cyc;
    bus.bcdEntrada = 12'h144;
    bus.banderaLista = 1'b1;
    sb.push_back('{es_error: 1'b0, valor: 144, ciclo: k + 12});
    sb.push_back('{es_error: 1'b0, valor: 500, ciclo: k + 24});
    model_res = 500;
    @(posedge reloj);
    #1;
    bus.bcdEntrada = 12'h500;
    repeat (12) @(posedge reloj);
    #1;
    bus.banderaLista = 1'b0;
    bus.bcdEntrada = 12'($urandom);
    esperar_vacio();
    chk("resultado_b2b", int'(bus.resultado), 500);

    for (int n = 0; n < 30; n++) begin
      v = '0;
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(0, 5) == 0) v[4*d +: 4] = 4'($urandom_range(0, 15));
        else v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      arrancar(v);
    end

    // Reset in the middle of converting 777.
    bus.bcdEntrada = 12'h777;
    bus.banderaLista = 1'b1;
    @(posedge reloj);
    #1;
    bus.banderaLista = 1'b0;
    repeat (5) @(posedge reloj);
    #1 reinicio = 1'b1;
    sb.delete();
    model_res = 0;
    #1;
    chk_reposo("reset_medio");
    repeat (2) @(posedge reloj);
    #1 reinicio = 1'b0;
    repeat (20) @(posedge reloj);
    #1;
    chk_reposo("tras_abortar");
    arrancar(12'h042);
    chk("resultado_final", int'(bus.resultado), 42);

    repeat (5) @(posedge reloj);
    chk("scoreboard_vacio", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
